// File: rtl/ring_rotation_monitor.sv
// Checks that a WIDTH-bit ring register rotates right by one bit per clock after each preset load.
// Define RING_NOTOUT_CHECK_EN to add ringNotIn and require it to be the complement of ringIn.
module ring_rotation_monitor #(
    parameter int WIDTH       = 5,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clockpulse,
    input  logic                   clear,
    input  logic                   loadSeen,
    input  logic [WIDTH-1:0]       ringIn,
`ifdef RING_NOTOUT_CHECK_EN
    input  logic [WIDTH-1:0]       ringNotIn,
`endif
    output logic                   locked,
    output logic                   rotationError,
    output logic [2:0]             position,
    output logic [COUNT_WIDTH-1:0] revolutionCount,
    output logic [COUNT_WIDTH-1:0] errorCount
);

    typedef enum logic [1:0] {IDLE, ARM, TRACK, FAULT} state_t;

    state_t                 stateQ, stateD;
    logic [WIDTH-1:0]       prevQ, prevD;
    logic [WIDTH-1:0]       homeQ, homeD;
    logic                   lockedQ, lockedD;
    logic                   rotErrQ, rotErrD;
    logic [2:0]             posQ, posD;
    logic [COUNT_WIDTH-1:0] revQ, revD;
    logic [COUNT_WIDTH-1:0] errQ, errD;

    logic [WIDTH-1:0]       expected;
    logic [COUNT_WIDTH-1:0] errSat;
    logic                   lastPos;
    logic                   rotationBad;
    logic                   notOutBad;

    assign expected    = {prevQ[0], prevQ[WIDTH-1:1]};
    assign lastPos     = (posQ == 3'(WIDTH - 1));
    assign rotationBad = (ringIn != expected) || (lastPos && (ringIn != homeQ));
    assign errSat      = (errQ == '1) ? errQ : errQ + COUNT_WIDTH'(1);
`ifdef RING_NOTOUT_CHECK_EN
    assign notOutBad   = (ringNotIn != ~ringIn);
`else
    assign notOutBad   = 1'b0;
`endif

    always_comb begin
        stateD  = stateQ;
        prevD   = prevQ;
        homeD   = homeQ;
        lockedD = lockedQ;
        rotErrD = rotErrQ;
        posD    = posQ;
        revD    = revQ;
        errD    = errQ;
        // A load restarts tracking from any state, even on an edge that would otherwise fault.
        if (loadSeen) begin
            stateD  = ARM;
            lockedD = 1'b0;
            rotErrD = 1'b0;
            posD    = 3'd0;
        end else begin
            case (stateQ)
                ARM: begin
                    if (notOutBad) begin
                        stateD  = FAULT;
                        lockedD = 1'b0;
                        rotErrD = 1'b1;
                        errD    = errSat;
                    end else begin
                        stateD  = TRACK;
                        prevD   = ringIn;
                        homeD   = ringIn;
                        posD    = 3'd0;
                        lockedD = 1'b1;
                    end
                end
                TRACK: begin
                    if (rotationBad || notOutBad) begin
                        stateD  = FAULT;
                        lockedD = 1'b0;
                        rotErrD = 1'b1;
                        errD    = errSat;
                    end else begin
                        prevD = ringIn;
                        if (lastPos) begin
                            posD = 3'd0;
                            revD = revQ + COUNT_WIDTH'(1);
                        end else begin
                            posD = posQ + 3'd1;
                        end
                    end
                end
                default: begin
                    lockedD = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            stateQ  <= IDLE;
            prevQ   <= '0;
            homeQ   <= '0;
            lockedQ <= 1'b0;
            rotErrQ <= 1'b0;
            posQ    <= 3'd0;
            revQ    <= '0;
            errQ    <= '0;
        end else begin
            stateQ  <= stateD;
            prevQ   <= prevD;
            homeQ   <= homeD;
            lockedQ <= lockedD;
            rotErrQ <= rotErrD;
            posQ    <= posD;
            revQ    <= revD;
            errQ    <= errD;
        end
    end

    assign locked          = lockedQ;
    assign rotationError   = rotErrQ;
    assign position        = posQ;
    assign revolutionCount = revQ;
    assign errorCount      = errQ;

endmodule

// File: tb/tb_ring_rotation_monitor.sv
// Self-checking bench for ring_rotation_monitor: directed scenarios plus randomized traffic
// compared against a model that tracks the home word and the number of shifts since capture.
`timescale 1ns/1ps
module tb_ring_rotation_monitor;

    localparam int W  = 5;
    localparam int CW = 8;
`ifdef RING_NOTOUT_CHECK_EN
    localparam bit NOT_CHECK = 1'b1;
`else
    localparam bit NOT_CHECK = 1'b0;
`endif

    logic          clockpulse = 1'b0;
    logic          clear      = 1'b1;
    logic          loadSeen   = 1'b0;
    logic [W-1:0]  ringIn     = '0;
    logic [W-1:0]  ringNotIn  = '1;
    logic          locked;
    logic          rotationError;
    logic [2:0]    position;
    logic [CW-1:0] revolutionCount;
    logic [CW-1:0] errorCount;

    int checks   = 0;
    int failures = 0;

    // Reference model: home word, shifts since capture, and plain counters.
    bit           mArming   = 1'b0;
    bit           mTracking = 1'b0;
    bit           mFaulted  = 1'b0;
    logic [W-1:0] mHome     = '0;
    int           mShifts   = 0;
    int           mRevs     = 0;
    int           mErrors   = 0;

    ring_rotation_monitor #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clockpulse      (clockpulse),
        .clear           (clear),
        .loadSeen        (loadSeen),
        .ringIn          (ringIn),
`ifdef RING_NOTOUT_CHECK_EN
        .ringNotIn       (ringNotIn),
`endif
        .locked          (locked),
        .rotationError   (rotationError),
        .position        (position),
        .revolutionCount (revolutionCount),
        .errorCount      (errorCount)
    );

    always #5 clockpulse = ~clockpulse;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] rotr(input logic [W-1:0] w, input int k);
        logic [2*W-1:0] dbl;
        int r;
        r   = k % W;
        dbl = {w, w};
        return dbl[r +: W];
    endfunction

    function automatic logic [W-1:0] nextWord();
        return rotr(mHome, mShifts + 1);
    endfunction

    function automatic logic [20:0] expVec();
        return {mTracking, mFaulted, 3'(mShifts % W), CW'(mRevs), CW'(mErrors)};
    endfunction

    function automatic logic [20:0] obsVec();
        return {locked, rotationError, position, revolutionCount, errorCount};
    endfunction

    task automatic modelFault();
        mTracking = 1'b0;
        mArming   = 1'b0;
        mFaulted  = 1'b1;
        if (mErrors < 255) mErrors++;
    endtask

    task automatic modelStep(input bit clr, input bit ld, input logic [W-1:0] r, input logic [W-1:0] n);
        bit notBad;
        notBad = NOT_CHECK && (n != ~r);
        if (clr) begin
            mArming = 0; mTracking = 0; mFaulted = 0;
            mHome = '0; mShifts = 0; mRevs = 0; mErrors = 0;
        end else if (ld) begin
            mArming = 1; mTracking = 0; mFaulted = 0; mShifts = 0;
        end else if (mArming) begin
            if (notBad) modelFault();
            else begin
                mArming = 0; mTracking = 1; mHome = r; mShifts = 0;
            end
        end else if (mTracking) begin
            if (notBad || r != nextWord()) modelFault();
            else begin
                mShifts++;
                if (mShifts % W == 0) mRevs = (mRevs + 1) % 256;
            end
        end
    endtask

    task automatic tick(input bit clr, input bit ld, input logic [W-1:0] r, input logic [W-1:0] n);
        @(negedge clockpulse);
        clear     = clr;
        loadSeen  = ld;
        ringIn    = r;
        ringNotIn = n;
        modelStep(clr, ld, r, n);
        @(posedge clockpulse);
        #1;
    endtask

    task automatic applyStimulus(input bit clr, input bit ld, input logic [W-1:0] r);
        tick(clr, ld, r, ~r);
    endtask

    task automatic test_reset();
        logic [W-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w = W'($urandom);
            applyStimulus(i < 2, 1'b0, w);
            checks++;
            if (obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL reset_model cyc%0d: got %h expected %h", i, obsVec(), expVec());
            end
            checks++;
            if (obsVec() !== 21'd0) begin
                failures++;
                $display("[TB] FAIL reset_zero cyc%0d: got %h expected 0", i, obsVec());
            end
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] seq [0:5];
        seq[0] = 5'b11000; seq[1] = 5'b01100; seq[2] = 5'b00110;
        seq[3] = 5'b00011; seq[4] = 5'b10001; seq[5] = 5'b11000;
        applyStimulus(1'b0, 1'b1, 5'b10101);
        applyStimulus(1'b0, 1'b0, seq[0]);
        checks++;
        if (locked !== 1'b1 || position !== 3'd0) begin
            failures++;
            $display("[TB] FAIL rotation_capture: got locked=%b pos=%0d expected locked=1 pos=0", locked, position);
        end
        for (int rev = 1; rev <= 2; rev++) begin
            for (int i = 1; i <= 5; i++) begin
                applyStimulus(1'b0, 1'b0, seq[i]);
                checks++;
                if (obsVec() !== expVec() || position !== 3'(i % 5)) begin
                    failures++;
                    $display("[TB] FAIL rotation_step rev%0d i%0d: got %h expected %h", rev, i, obsVec(), expVec());
                end
            end
            checks++;
            if (revolutionCount !== CW'(rev) || errorCount !== 8'd0 || locked !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rotation_revs: got revs=%0d errs=%0d expected revs=%0d errs=0", revolutionCount, errorCount, rev);
            end
        end
    endtask

    task automatic test_fault();
        applyStimulus(1'b0, 1'b0, 5'b01100);
        applyStimulus(1'b0, 1'b0, 5'b10110);
        checks++;
        if (rotationError !== 1'b1 || locked !== 1'b0 || errorCount !== 8'd1 || position !== 3'd1) begin
            failures++;
            $display("[TB] FAIL fault_entry: got err=%b lock=%b cnt=%0d pos=%0d expected 1 0 1 1", rotationError, locked, errorCount, position);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, W'($urandom));
            checks++;
            if (obsVec() !== expVec() || errorCount !== 8'd1 || position !== 3'd1) begin
                failures++;
                $display("[TB] FAIL fault_sticky cyc%0d: got %h expected %h", i, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_reload();
        applyStimulus(1'b0, 1'b1, 5'b10100);
        checks++;
        if (rotationError !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reload_arm: got err=%b lock=%b expected 0 0", rotationError, locked);
        end
        applyStimulus(1'b0, 1'b0, 5'b10100);
        checks++;
        if (locked !== 1'b1 || position !== 3'd0 || errorCount !== 8'd1) begin
            failures++;
            $display("[TB] FAIL reload_capture: got lock=%b pos=%0d cnt=%0d expected 1 0 1", locked, position, errorCount);
        end
        applyStimulus(1'b0, 1'b0, 5'b01010);
        checks++;
        if (locked !== 1'b1 || position !== 3'd1 || errorCount !== 8'd1 || obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL reload_step: got %h expected %h", obsVec(), expVec());
        end
    endtask

    task automatic test_load_priority();
        applyStimulus(1'b0, 1'b1, 5'b11111);
        checks++;
        if (rotationError !== 1'b0 || locked !== 1'b0 || errorCount !== 8'd1) begin
            failures++;
            $display("[TB] FAIL load_wins: got err=%b lock=%b cnt=%0d expected 0 0 1", rotationError, locked, errorCount);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom));
            checks++;
            if (locked !== 1'b0 || obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL load_held cyc%0d: got %h expected %h", i, obsVec(), expVec());
            end
        end
        applyStimulus(1'b0, 1'b0, 5'b00111);
        applyStimulus(1'b0, 1'b0, 5'b10011);
        checks++;
        if (locked !== 1'b1 || position !== 3'd1 || obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL load_release: got %h expected %h", obsVec(), expVec());
        end
    endtask

    task automatic test_clear();
        applyStimulus(1'b1, 1'b0, 5'b00000);
        applyStimulus(1'b0, 1'b1, 5'b11000);
        applyStimulus(1'b0, 1'b0, 5'b11000);
        for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b0, nextWord());
        checks++;
        if (position !== 3'd3 || revolutionCount !== 8'd2 || locked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clear_setup: got pos=%0d revs=%0d expected pos=3 revs=2", position, revolutionCount);
        end
        applyStimulus(1'b1, 1'b0, nextWord());
        checks++;
        if (obsVec() !== 21'd0) begin
            failures++;
            $display("[TB] FAIL clear_mid_track: got %h expected 0", obsVec());
        end
        applyStimulus(1'b0, 1'b0, 5'b01100);
        checks++;
        if (obsVec() !== 21'd0 || obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL clear_idle: got %h expected 0", obsVec());
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] w;
        for (int i = 0; i < 258; i++) begin
            w = W'($urandom);
            applyStimulus(1'b0, 1'b1, w);
            applyStimulus(1'b0, 1'b0, w);
            applyStimulus(1'b0, 1'b0, nextWord() ^ W'($urandom_range(1, 31)));
            if (i == 100) begin
                checks++;
                if (errorCount !== 8'd101) begin
                    failures++;
                    $display("[TB] FAIL sat_midway: got %0d expected 101", errorCount);
                end
            end
        end
        checks++;
        if (errorCount !== 8'hFF || rotationError !== 1'b1 || obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL sat_hold: got cnt=%0d obs=%h expected cnt=255 obs=%h", errorCount, obsVec(), expVec());
        end
    endtask

    task automatic test_random();
        int p;
        logic [W-1:0] w, n;
        applyStimulus(1'b1, 1'b0, 5'b00000);
        for (int i = 0; i < 600; i++) begin
            p = $urandom_range(0, 99);
            w = mTracking ? nextWord() : W'($urandom);
            if (p < 6) w = w ^ W'($urandom_range(1, 31));
            n = ~w;
            if (NOT_CHECK && $urandom_range(0, 99) < 3) n = n ^ W'($urandom_range(1, 31));
            tick(p == 99, (p >= 88 && p < 98), w, n);
            checks++;
            if (obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL random cyc%0d: got %h expected %h", i, obsVec(), expVec());
            end
        end
    endtask

`ifdef RING_NOTOUT_CHECK_EN
    task automatic test_notout();
        applyStimulus(1'b1, 1'b0, 5'b00000);
        applyStimulus(1'b0, 1'b1, 5'b11000);
        applyStimulus(1'b0, 1'b0, 5'b11000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, nextWord());
        tick(1'b0, 1'b0, 5'b11000, 5'b00110);
        checks++;
        if (rotationError !== 1'b1 || locked !== 1'b0 || errorCount !== 8'd1) begin
            failures++;
            $display("[TB] FAIL notout_fault: got err=%b lock=%b cnt=%0d expected 1 0 1", rotationError, locked, errorCount);
        end
        applyStimulus(1'b0, 1'b1, 5'b11000);
        applyStimulus(1'b0, 1'b0, 5'b11000);
        tick(1'b0, 1'b0, 5'b10101, 5'b00000);
        checks++;
        if (rotationError !== 1'b1 || errorCount !== 8'd2 || obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL notout_double: got cnt=%0d obs=%h expected cnt=2 obs=%h", errorCount, obsVec(), expVec());
        end
    endtask
`endif

    initial begin
        $display("[TB] ring_rotation_monitor bench start");
        test_reset();
        test_rotation();
        test_fault();
        test_reload();
        test_load_priority();
        test_clear();
        test_saturation();
`ifdef RING_NOTOUT_CHECK_EN
        test_notout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
